// File: rtl/reconf_tile_driver_if.sv
// Command, operand-beat and result-beat handshakes between the stream fabric and
// reconf_tile_driver. The master is the fabric side; the slave is the driver.
interface reconf_tile_driver_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_mode;
    logic [DATA_W-1:0]       cmd_scal;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic                    out_last;
    logic                    out_is_scal;

    modport master (
        output cmd_valid, cmd_mode, cmd_scal, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data, out_last, out_is_scal
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_scal, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data, out_last, out_is_scal
    );
endinterface

// File: rtl/reconf_tile_driver.sv
// Initiator/collector for one reconfigurable mul/adder-tree tile: gathers operand beats into
// full tile vectors, waits out the tile pipeline, then streams the result back as beats.
module reconf_tile_driver #(
    parameter int unsigned TILE_SIZE = 128,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned LANES     = 16,
    parameter int unsigned PIPE_LAT  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    reconf_tile_driver_if.slave           bus,
    output logic [TILE_SIZE*DATA_W-1:0]   tile_vec1,
    output logic [TILE_SIZE*DATA_W-1:0]   tile_vec2,
    output logic [DATA_W-1:0]             tile_scal,
    output logic                          tile_control,
    input  logic [DATA_W-1:0]             tile_o_scal,
    input  logic [TILE_SIZE*DATA_W-1:0]   tile_o_vec
);
    localparam int unsigned BEATS   = TILE_SIZE / LANES;
    localparam int unsigned BEAT_W  = LANES * DATA_W;
    localparam int unsigned BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WAIT_W  = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);
    localparam logic [WAIT_W-1:0]  LAST_WAIT = WAIT_W'(PIPE_LAT);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_DRAIN} state_e;

    state_e                         state_q;
    logic [BEAT_CW-1:0]             beat_q;
    logic [BEAT_CW-1:0]             beat_inc;
    logic [WAIT_W-1:0]              wait_q;
    logic [BEATS-1:0][BEAT_W-1:0]   vec1_q;
    logic [BEATS-1:0][BEAT_W-1:0]   vec2_q;
    logic [BEATS-1:0][BEAT_W-1:0]   res_q;
    logic [DATA_W-1:0]              scal_q;
    logic                           mode_q;
    logic                           cmd_ready_q;
    logic                           in_ready_q;
    logic                           out_valid_q;
    logic [BEAT_W-1:0]              out_data_q;
    logic                           out_last_q;
    logic                           out_is_scal_q;

    assign beat_inc = beat_q + BEAT_CW'(1);

    // Single sequential FSM; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            wait_q        <= '0;
            vec1_q        <= '0;
            vec2_q        <= '0;
            res_q         <= '0;
            scal_q        <= '0;
            mode_q        <= 1'b0;
            cmd_ready_q   <= 1'b0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            out_is_scal_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        mode_q      <= bus.cmd_mode;
                        scal_q      <= bus.cmd_mode ? bus.cmd_scal : '0;
                        beat_q      <= '0;
                        state_q     <= S_LOAD_A;
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (bus.in_valid && in_ready_q) begin
                        if (state_q == S_LOAD_A) vec1_q[beat_q] <= bus.in_data;
                        else                     vec2_q[beat_q] <= bus.in_data;
                        if (beat_q == LAST_BEAT) begin
                            beat_q <= '0;
                            if (state_q == S_LOAD_A && !mode_q) begin
                                state_q <= S_LOAD_B;
                            end else begin
                                state_q    <= S_EXEC;
                                in_ready_q <= 1'b0;
                                wait_q     <= '0;
                            end
                        end else begin
                            beat_q <= beat_inc;
                        end
                    end
                end
                S_EXEC: begin
                    // Tile operands have been stable for PIPE_LAT+1 cycles on the final edge.
                    if (wait_q == LAST_WAIT) begin
                        state_q     <= S_DRAIN;
                        out_valid_q <= 1'b1;
                        beat_q      <= '0;
                        if (mode_q) begin
                            res_q         <= tile_o_vec;
                            out_data_q    <= tile_o_vec[BEAT_W-1:0];
                            out_last_q    <= (LAST_BEAT == '0);
                            out_is_scal_q <= 1'b0;
                        end else begin
                            out_data_q    <= BEAT_W'(tile_o_scal);
                            out_last_q    <= 1'b1;
                            out_is_scal_q <= 1'b1;
                        end
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            out_data_q <= res_q[beat_inc];
                            out_last_q <= (beat_inc == LAST_BEAT);
                            beat_q     <= beat_inc;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_is_scal = out_is_scal_q;
    assign tile_vec1       = vec1_q;
    assign tile_vec2       = vec2_q;
    assign tile_scal       = scal_q;
    assign tile_control    = mode_q;
endmodule
